marquee_speed_scheduler: RTL and testbench

//  Control/sequencing front-end for the 4-LED marquee on the lab board.
//  - Debounces three raw push-buttons: speed-up, speed-down, run/pause.
//  - Holds a 4-level speed setting and a RUN/PAUSE state.
//  - Emits the marquee step tick and the LED position (one-hot LED drive).
//  - Sits between board buttons and the LED pins; sole owner of step timing.

---
 rtl/marquee_pkg.sv | 19 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/marquee_speed_scheduler.sv | 142 ++++++++++++++
 tb/tb_marquee_speed_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/marquee_pkg.sv
// Shared types and constants for the marquee speed scheduler.
// Holds the sequencing states, the speed level type and the level ceiling.
package marquee_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [1:0] speed_level_t;

    localparam speed_level_t MAX_LEVEL = 2'd3;

    function automatic logic [3:0] level_onehot(input speed_level_t lvl);
        return 4'b0001 << lvl;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and rising-edge press pulse.
// A new level is accepted only after the synchronised value holds for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          sync_d;
    logic [CW-1:0] cnt;

    // sync_d trails sync_b by one cycle so any change restarts the stability count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            sync_d <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            sync_d <= sync_b;
            press  <= 1'b0;
            if (sync_b != sync_d) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else if (level != sync_d) begin
                level <= sync_d;
                press <= sync_d;
            end
        end
    end

endmodule

// File: rtl/marquee_speed_scheduler.sv
// Marquee sequencer: debounced buttons drive a RUN/PAUSE FSM, a 4-level speed setting
// and the step prescaler that advances the one-hot LED position.
//
//  state | meaning
//  IDLE  | after reset, LEDs dark, prescaler held at 0
//  RUN   | prescaler counting, step fires at terminal count, pos advances
//  PAUSE | prescaler and pos frozen, LED keeps showing pos
module marquee_speed_scheduler
    import marquee_pkg::*;
#(
    parameter int CLK_FREQ        = 125000000,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int NUM_LEDS        = 4,
    parameter int BASE_PERIOD     = 2 * CLK_FREQ
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_run,
    output logic                        step,
    output logic [$clog2(NUM_LEDS)-1:0] pos,
    output logic [NUM_LEDS-1:0]         led,
    output logic [3:0]                  speed_led,
    output logic                        running
);

    localparam int CNT_W = $clog2(BASE_PERIOD);
    localparam int POS_W = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] LED_ONE  = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    logic up_press, down_press, run_press;
    logic up_level, down_level, run_level;
    logic unused_levels;

    state_t           state, state_n;
    speed_level_t     level, level_n;
    logic [CNT_W-1:0] cnt, cnt_n, term;
    logic [POS_W-1:0] pos_n;
    logic             step_n;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_up),
        .level (up_level),
        .press (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_down),
        .level (down_level),
        .press (down_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_run),
        .level (run_level),
        .press (run_press)
    );

    // Only the press pulses matter here; the held levels are kept for debug visibility.
    assign unused_levels = ^{up_level, down_level, run_level};

    // Step period halves per level; terminal count uses the level in force this cycle.
    assign term = CNT_W'((BASE_PERIOD >> level) - 1);

    always_comb begin
        state_n = state;
        level_n = level;
        cnt_n   = cnt;
        pos_n   = pos;
        step_n  = 1'b0;

        if (state == RUN) begin
            if (cnt == term) begin
                cnt_n  = '0;
                step_n = 1'b1;
                pos_n  = (pos == POS_LAST) ? '0 : pos + 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end

        // A real level change restarts the period; saturated presses leave cnt alone.
        if (up_press && !down_press && level != MAX_LEVEL) begin
            level_n = level + 1'b1;
            cnt_n   = '0;
        end else if (down_press && !up_press && level != '0) begin
            level_n = level - 1'b1;
            cnt_n   = '0;
        end

        if (run_press) begin
            case (state)
                IDLE: begin
                    state_n = RUN;
                    cnt_n   = '0;
                    pos_n   = '0;
                end
                RUN:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= '0;
            cnt   <= '0;
            pos   <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_n;
            level <= level_n;
            cnt   <= cnt_n;
            pos   <= pos_n;
            step  <= step_n;
        end
    end

    // Display outputs are registered from the next-state values so they track state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led       <= '0;
            speed_led <= 4'b0001;
            running   <= 1'b0;
        end else begin
            led       <= (state_n == IDLE) ? '0 : (LED_ONE << pos_n);
            speed_led <= level_onehot(level_n);
            running   <= (state_n == RUN);
        end
    end

endmodule

// File: tb/tb_marquee_speed_scheduler.sv
// Randomised bench for marquee_speed_scheduler against a cycle-level behavioural model.
// Button activity is scheduled as press events at a fixed debounce latency.
module tb_marquee_speed_scheduler;

    localparam int CLK_FREQ = 8;
    localparam int BASE     = 16;
    localparam int DB       = 4;
    localparam int N        = 4;
    localparam int LAT      = DB + 4;
    localparam int MAXC     = 16384;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_run;
    logic       step;
    logic [1:0] pos;
    logic [3:0] led;
    logic [3:0] speed_led;
    logic       running;

    always #5 clk = ~clk;

    marquee_speed_scheduler #(
        .CLK_FREQ        (CLK_FREQ),
        .DEBOUNCE_CYCLES (DB),
        .NUM_LEDS        (N),
        .BASE_PERIOD     (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_run   (btn_run),
        .step      (step),
        .pos       (pos),
        .led       (led),
        .speed_led (speed_led),
        .running   (running)
    );

    int vec_cnt;
    int err_cnt;
    int cyc;

    int m_state, m_level, m_elapsed, m_pos;
    bit m_step;

    bit ev [0:2][0:MAXC-1];
    int hi_left [0:2];
    int busy_until [0:2];

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {20'd0, step, pos, led, speed_led, running};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [3:0] e_led;
        logic [3:0] e_spd;
        logic [1:0] e_pos;
        e_led = (m_state == M_IDLE) ? 4'd0 : 4'(1 << m_pos);
        e_spd = 4'(1 << m_level);
        e_pos = 2'(m_pos);
        return {20'd0, m_step, e_pos, e_led, e_spd, (m_state == M_RUN)};
    endfunction

    task automatic model_reset();
        m_state   = M_IDLE;
        m_level   = 0;
        m_elapsed = 0;
        m_pos     = 0;
        m_step    = 1'b0;
    endtask

    task automatic model_edge();
        bit up, dn, rn;
        int period, new_level;
        if (!rst_n) begin
            model_reset();
            return;
        end
        up = (cyc < MAXC) ? ev[0][cyc] : 1'b0;
        dn = (cyc < MAXC) ? ev[1][cyc] : 1'b0;
        rn = (cyc < MAXC) ? ev[2][cyc] : 1'b0;
        period = BASE >> m_level;
        m_step = 1'b0;
        if (m_state == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == period) begin
                m_elapsed = 0;
                m_pos     = (m_pos + 1) % N;
                m_step    = 1'b1;
            end
        end
        new_level = m_level;
        if (up && !dn) new_level = (m_level < 3) ? m_level + 1 : 3;
        if (dn && !up) new_level = (m_level > 0) ? m_level - 1 : 0;
        if (new_level != m_level) begin
            m_level   = new_level;
            m_elapsed = 0;
        end
        if (rn) begin
            if (m_state == M_IDLE) begin
                m_state   = M_RUN;
                m_elapsed = 0;
                m_pos     = 0;
            end else if (m_state == M_RUN) begin
                m_state = M_PAUSE;
            end else begin
                m_state = M_RUN;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_vec("outs", obs_vec(), exp_vec());
    endtask

    task automatic start_btn(input int b, input int len, input bit accepted);
        if (accepted && (cyc + LAT) < MAXC) ev[b][cyc + LAT] = 1'b1;
        hi_left[b]    = len;
        busy_until[b] = cyc + len + DB + 6;
    endtask

    task automatic drive_buttons();
        logic [2:0] raw;
        for (int b = 0; b < 3; b++) begin
            raw[b] = (hi_left[b] > 0);
            if (hi_left[b] > 0) hi_left[b]--;
        end
        btn_up   = raw[0];
        btn_down = raw[1];
        btn_run  = raw[2];
    endtask

    task automatic random_starts();
        int odds;
        for (int b = 0; b < 3; b++) begin
            if (cyc >= busy_until[b]) begin
                odds = (b == 2) ? 40 : 14;
                if ($urandom_range(0, odds) == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        start_btn(b, int'($urandom_range(1, DB)), 1'b0);
                    else
                        start_btn(b, int'($urandom_range(DB + 1, DB + 5)), 1'b1);
                end
            end
        end
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        repeat (n) begin
            if (rnd) random_starts();
            drive_buttons();
            tick();
        end
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_vec("async_rst", obs_vec(), exp_vec());
        for (int b = 0; b < 3; b++) begin
            hi_left[b]    = 0;
            busy_until[b] = cyc + DB + 8;
            for (int i = cyc + 1; i <= cyc + LAT + 1 && i < MAXC; i++) ev[b][i] = 1'b0;
        end
        drive_buttons();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_run  = 1'b0;
        for (int b = 0; b < 3; b++) begin
            hi_left[b]    = 0;
            busy_until[b] = 0;
        end
        model_reset();

        repeat (3) tick();
        rst_n = 1'b1;

        start_btn(2, 8, 1'b1);
        run_cycles(90, 1'b0);
        for (int k = 0; k < 4; k++) begin
            start_btn(0, 6, 1'b1);
            run_cycles(20, 1'b0);
        end
        run_cycles(12, 1'b0);
        for (int k = 0; k < 4; k++) begin
            start_btn(1, 6, 1'b1);
            run_cycles(20, 1'b0);
        end
        start_btn(0, 6, 1'b1);
        run_cycles(20, 1'b0);
        start_btn(0, 6, 1'b1);
        start_btn(1, 6, 1'b1);
        run_cycles(20, 1'b0);
        start_btn(2, 7, 1'b1);
        run_cycles(25, 1'b0);
        start_btn(0, 2, 1'b0);
        run_cycles(15, 1'b0);
        start_btn(0, DB, 1'b0);
        run_cycles(15, 1'b0);
        start_btn(2, DB + 1, 1'b1);
        run_cycles(40, 1'b0);

        repeat (6) begin
            run_cycles(int'($urandom_range(200, 900)), 1'b1);
            async_reset();
        end
        run_cycles(300, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
